// File: rtl/pipe_hazard_ctrl.sv
// Hazard detection and multicycle divider sequencing for the 5-stage pipeline.
// Produces PC/IF-ID enables, ID/EX bubble, IF flush, divider issue and a stall counter.
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int DIV_LATENCY = 32,
    parameter int PERF_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_is_div,
    input  logic              id_reads_hilo,
    input  logic              id_beq,
    input  logic              id_bne,
    input  logic              id_jump,
    input  logic              id_jr,
    input  logic              cmp_eq,
    input  logic              ex_regWrite,
    input  logic              ex_memRead,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              mem_memRead,
    input  logic [REG_AW-1:0] mem_dst,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              if_flush,
    output logic              div_start,
    output logic              div_busy,
    output logic [PERF_W-1:0] stall_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } div_state_t;

    localparam logic [7:0] LAT = 8'(DIV_LATENCY);

    div_state_t  state, state_nxt;
    logic [7:0]  cnt, cnt_nxt;
    logic        ex_nz, mem_nz;
    logic        br_src_rt, is_br;
    logic        ex_hit, mem_hit;
    logic        lu, br, dv, stall, taken;

    // Register 0 is never a real producer, so every match needs a nonzero destination.
    always_comb begin
        ex_nz     = (ex_dst != '0);
        mem_nz    = (mem_dst != '0);
        br_src_rt = id_beq | id_bne;
        is_br     = br_src_rt | id_jr;
        ex_hit    = ex_nz  & ((ex_dst == id_rs)  | (br_src_rt & (ex_dst == id_rt)));
        mem_hit   = mem_nz & ((mem_dst == id_rs) | (br_src_rt & (mem_dst == id_rt)));
        lu        = ex_memRead & ex_nz & ((ex_dst == id_rs) | (id_uses_rt & (ex_dst == id_rt)));
        br        = is_br & ((ex_regWrite & ex_hit) | (mem_memRead & mem_hit));
        dv        = div_busy & (id_is_div | id_reads_hilo);
        stall     = id_valid & (lu | br | dv);
        taken     = id_jump | id_jr | (id_beq & cmp_eq) | (id_bne & ~cmp_eq);
    end

    assign div_busy = (cnt != 8'd0);

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        if_flush    = 1'b0;
        if (rst) begin
            idex_bubble = 1'b1;
            if_flush    = 1'b1;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            if_flush    = id_valid & taken;
        end
    end

    // Divider sequencing: a DIV that arrives while busy is stalled, never queued.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_start = 1'b0;
        case (state)
            IDLE: begin
                if (id_valid && id_is_div && !stall && !rst) begin
                    div_start = 1'b1;
                    cnt_nxt   = LAT;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                cnt_nxt = (cnt != 8'd0) ? cnt - 8'd1 : 8'd0;
                if (cnt <= 8'd1) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {PERF_W{1'b1}})) begin
            stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: two instances (latency 3 / 16-bit counter and
// latency 4 / 2-bit counter) share stimulus and are compared against a behavioural model.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       id_valid;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_uses_rt;
        logic       id_is_div;
        logic       id_reads_hilo;
        logic       id_beq;
        logic       id_bne;
        logic       id_jump;
        logic       id_jr;
        logic       cmp_eq;
        logic       ex_regWrite;
        logic       ex_memRead;
        logic [4:0] ex_dst;
        logic       mem_memRead;
        logic [4:0] mem_dst;
    } stim_t;

    typedef struct packed {
        bit stall;
        bit pc_write;
        bit ifid_write;
        bit idex_bubble;
        bit if_flush;
        bit div_start;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs, id_rt;
    logic       id_uses_rt, id_is_div, id_reads_hilo;
    logic       id_beq, id_bne, id_jump, id_jr, cmp_eq;
    logic       ex_regWrite, ex_memRead;
    logic [4:0] ex_dst;
    logic       mem_memRead;
    logic [4:0] mem_dst;

    logic        pc_write_a, ifid_write_a, idex_bubble_a, if_flush_a, div_start_a, div_busy_a;
    logic [15:0] stall_cycles_a;
    logic        pc_write_b, ifid_write_b, idex_bubble_b, if_flush_b, div_start_b, div_busy_b;
    logic [1:0]  stall_cycles_b;

    int vectors     = 0;
    int miscompares = 0;
    int busy_left[2];
    int perf[2];
    int lat[2]      = '{3, 4};
    int perf_max[2] = '{65535, 3};
    bit model_valid = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .DIV_LATENCY(3), .PERF_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_is_div(id_is_div), .id_reads_hilo(id_reads_hilo),
        .id_beq(id_beq), .id_bne(id_bne), .id_jump(id_jump), .id_jr(id_jr), .cmp_eq(cmp_eq),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_dst(ex_dst),
        .mem_memRead(mem_memRead), .mem_dst(mem_dst),
        .pc_write(pc_write_a), .ifid_write(ifid_write_a), .idex_bubble(idex_bubble_a),
        .if_flush(if_flush_a), .div_start(div_start_a), .div_busy(div_busy_a),
        .stall_cycles(stall_cycles_a)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .DIV_LATENCY(4), .PERF_W(2)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_is_div(id_is_div), .id_reads_hilo(id_reads_hilo),
        .id_beq(id_beq), .id_bne(id_bne), .id_jump(id_jump), .id_jr(id_jr), .cmp_eq(cmp_eq),
        .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_dst(ex_dst),
        .mem_memRead(mem_memRead), .mem_dst(mem_dst),
        .pc_write(pc_write_b), .ifid_write(ifid_write_b), .idex_bubble(idex_bubble_b),
        .if_flush(if_flush_b), .div_start(div_start_b), .div_busy(div_busy_b),
        .stall_cycles(stall_cycles_b)
    );

    function automatic bit reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // What the outputs must be for the current inputs, given whether a division is in flight.
    function automatic exp_t model_outputs(input bit busy);
        exp_t e;
        bit lu, br, dv, rt_src, ex_h, mem_h, taken;
        rt_src = id_beq || id_bne;
        lu     = ex_memRead && (reg_hit(ex_dst, id_rs) || (id_uses_rt && reg_hit(ex_dst, id_rt)));
        ex_h   = reg_hit(ex_dst, id_rs) || (rt_src && reg_hit(ex_dst, id_rt));
        mem_h  = reg_hit(mem_dst, id_rs) || (rt_src && reg_hit(mem_dst, id_rt));
        br     = (id_beq || id_bne || id_jr) && ((ex_regWrite && ex_h) || (mem_memRead && mem_h));
        dv     = busy && (id_is_div || id_reads_hilo);
        taken  = id_jump || id_jr || (id_beq && cmp_eq) || (id_bne && !cmp_eq);
        e.stall = id_valid && (lu || br || dv);
        if (rst) begin
            e.pc_write    = 1'b1;
            e.ifid_write  = 1'b1;
            e.idex_bubble = 1'b1;
            e.if_flush    = 1'b1;
            e.div_start   = 1'b0;
        end else begin
            e.pc_write    = !e.stall;
            e.ifid_write  = !e.stall;
            e.idex_bubble = e.stall;
            e.if_flush    = id_valid && !e.stall && taken;
            e.div_start   = id_valid && id_is_div && !e.stall && !busy;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkInstance(input string tag, input int i,
                                 input logic pcw, input logic ifw, input logic bub,
                                 input logic fl, input logic ds, input logic busy,
                                 input logic [31:0] sc);
        exp_t e;
        e = model_outputs(busy_left[i] > 0);
        checkOutput({tag, ".pc_write"},     pcw,  e.pc_write);
        checkOutput({tag, ".ifid_write"},   ifw,  e.ifid_write);
        checkOutput({tag, ".idex_bubble"},  bub,  e.idex_bubble);
        checkOutput({tag, ".if_flush"},     fl,   e.if_flush);
        checkOutput({tag, ".div_start"},    ds,   e.div_start);
        checkOutput({tag, ".div_busy"},     busy, (busy_left[i] > 0) ? 1 : 0);
        checkOutput({tag, ".stall_cycles"}, sc,   perf[i]);
    endtask

    // Model state advances on the same edge as the DUT registers.
    always @(posedge clk) begin : model_update
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            e = model_outputs(busy_left[i] > 0);
            if (rst) begin
                busy_left[i] = 0;
                perf[i]      = 0;
            end else begin
                if (e.div_start)
                    busy_left[i] = lat[i];
                else if (busy_left[i] > 0)
                    busy_left[i] = busy_left[i] - 1;
                if (e.stall && perf[i] < perf_max[i])
                    perf[i] = perf[i] + 1;
            end
        end
        if (rst) model_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            checkInstance("a", 0, pc_write_a, ifid_write_a, idex_bubble_a, if_flush_a,
                          div_start_a, div_busy_a, 32'(stall_cycles_a));
            checkInstance("b", 1, pc_write_b, ifid_write_b, idex_bubble_b, if_flush_b,
                          div_start_b, div_busy_b, 32'(stall_cycles_b));
        end
    end

    task automatic drive(input stim_t s);
        rst           = s.rst;
        id_valid      = s.id_valid;
        id_rs         = s.id_rs;
        id_rt         = s.id_rt;
        id_uses_rt    = s.id_uses_rt;
        id_is_div     = s.id_is_div;
        id_reads_hilo = s.id_reads_hilo;
        id_beq        = s.id_beq;
        id_bne        = s.id_bne;
        id_jump       = s.id_jump;
        id_jr         = s.id_jr;
        cmp_eq        = s.cmp_eq;
        ex_regWrite   = s.ex_regWrite;
        ex_memRead    = s.ex_memRead;
        ex_dst        = s.ex_dst;
        mem_memRead   = s.mem_memRead;
        mem_dst       = s.mem_dst;
    endtask

    // One pipeline cycle: inputs change just after the edge, then settle briefly.
    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        #1;
        drive(s);
        #1;
    endtask

    task automatic idleCycles(input int n);
        stim_t s;
        s = '0;
        for (int k = 0; k < n; k++) applyStimulus(s);
    endtask

    function automatic logic [4:0] pick_reg();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 3));
    endfunction

    initial begin
        stim_t s;
        int    sc0;
        int    cls;
        int    sat_seq[6] = '{0, 1, 2, 3, 3, 3};

        s = '0;
        s.rst = 1'b1;
        drive(s);
        applyStimulus(s);
        applyStimulus(s);

        // Reset aborts an in-flight division on the latency-4 instance.
        s = '0; s.id_valid = 1; s.id_is_div = 1;
        applyStimulus(s);
        checkOutput("rst_issue.div_start", div_start_b, 1);
        s = '0; s.id_valid = 1; s.id_reads_hilo = 1;
        applyStimulus(s);
        checkOutput("rst_busy.div_busy", div_busy_b, 1);
        checkOutput("rst_busy.pc_write", pc_write_b, 0);
        s = '0; s.rst = 1; s.id_valid = 1; s.id_is_div = 1;
        applyStimulus(s);
        checkOutput("rst_force.pc_write", pc_write_b, 1);
        checkOutput("rst_force.idex_bubble", idex_bubble_b, 1);
        checkOutput("rst_force.if_flush", if_flush_b, 1);
        checkOutput("rst_force.div_start", div_start_b, 0);
        checkOutput("rst_force.stall_cycles", stall_cycles_b, 1);
        s = '0; s.id_valid = 1; s.id_is_div = 1;
        applyStimulus(s);
        checkOutput("rst_after.div_busy", div_busy_b, 0);
        checkOutput("rst_after.stall_cycles", stall_cycles_b, 0);
        checkOutput("rst_after.div_start", div_start_b, 1);
        idleCycles(6);

        // Load-use stalls one cycle; a zero destination never stalls.
        sc0 = int'(stall_cycles_a);
        s = '0; s.id_valid = 1; s.id_rs = 8; s.ex_memRead = 1; s.ex_regWrite = 1; s.ex_dst = 8;
        applyStimulus(s);
        checkOutput("lu.pc_write", pc_write_a, 0);
        checkOutput("lu.ifid_write", ifid_write_a, 0);
        checkOutput("lu.idex_bubble", idex_bubble_a, 1);
        s = '0; s.id_valid = 1; s.id_rs = 8; s.mem_memRead = 1; s.mem_dst = 8;
        applyStimulus(s);
        checkOutput("lu_next.pc_write", pc_write_a, 1);
        checkOutput("lu_next.idex_bubble", idex_bubble_a, 0);
        checkOutput("lu_next.stall_cycles", stall_cycles_a, sc0 + 1);
        s = '0; s.id_valid = 1; s.id_rs = 0; s.ex_memRead = 1; s.ex_dst = 0;
        applyStimulus(s);
        checkOutput("lu_r0.pc_write", pc_write_a, 1);
        checkOutput("lu_r0.idex_bubble", idex_bubble_a, 0);

        // BEQ r9,r10 right behind LW r9: two stall cycles, then the taken flush.
        sc0 = int'(stall_cycles_a);
        s = '0; s.id_valid = 1; s.id_beq = 1; s.id_rs = 9; s.id_rt = 10; s.id_uses_rt = 1;
        s.cmp_eq = 1; s.ex_memRead = 1; s.ex_regWrite = 1; s.ex_dst = 9;
        applyStimulus(s);
        checkOutput("br_ld0.pc_write", pc_write_a, 0);
        checkOutput("br_ld0.if_flush", if_flush_a, 0);
        s.ex_memRead = 0; s.ex_regWrite = 0; s.ex_dst = 0; s.mem_memRead = 1; s.mem_dst = 9;
        applyStimulus(s);
        checkOutput("br_ld1.pc_write", pc_write_a, 0);
        checkOutput("br_ld1.if_flush", if_flush_a, 0);
        s.mem_memRead = 0; s.mem_dst = 0;
        applyStimulus(s);
        checkOutput("br_ld2.pc_write", pc_write_a, 1);
        checkOutput("br_ld2.if_flush", if_flush_a, 1);
        checkOutput("br_ld2.stall_cycles", stall_cycles_a, sc0 + 2);
        idleCycles(6);

        // Latency-3 divide followed by MFLO.
        s = '0; s.id_valid = 1; s.id_is_div = 1;
        applyStimulus(s);
        checkOutput("div.div_start", div_start_a, 1);
        s = '0; s.id_valid = 1; s.id_reads_hilo = 1;
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(s);
            checkOutput($sformatf("div_mflo%0d.pc_write", k), pc_write_a, 0);
            checkOutput($sformatf("div_mflo%0d.div_busy", k), div_busy_a, 1);
        end
        applyStimulus(s);
        checkOutput("div_mflo4.pc_write", pc_write_a, 1);
        checkOutput("div_mflo4.div_busy", div_busy_a, 0);
        idleCycles(6);

        // Back-to-back DIV waits in ID until the first one retires.
        s = '0; s.id_valid = 1; s.id_is_div = 1;
        applyStimulus(s);
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(s);
            checkOutput($sformatf("div_b2b%0d.div_start", k), div_start_a, 0);
        end
        applyStimulus(s);
        checkOutput("div_b2b4.div_start", div_start_a, 1);
        idleCycles(6);

        // BNE resolution, and JR behind an ALU producer of r31.
        s = '0; s.id_valid = 1; s.id_bne = 1; s.id_rs = 1; s.id_rt = 2; s.id_uses_rt = 1;
        applyStimulus(s);
        checkOutput("bne_taken.if_flush", if_flush_a, 1);
        checkOutput("bne_taken.pc_write", pc_write_a, 1);
        s.cmp_eq = 1;
        applyStimulus(s);
        checkOutput("bne_nt.if_flush", if_flush_a, 0);
        s = '0; s.id_valid = 1; s.id_jr = 1; s.id_rs = 31; s.ex_regWrite = 1; s.ex_dst = 31;
        applyStimulus(s);
        checkOutput("jr_stall.pc_write", pc_write_a, 0);
        checkOutput("jr_stall.if_flush", if_flush_a, 0);
        s.ex_regWrite = 0; s.ex_dst = 0;
        applyStimulus(s);
        checkOutput("jr_go.if_flush", if_flush_a, 1);
        checkOutput("jr_go.pc_write", pc_write_a, 1);

        // 2-bit stall counter saturates at 3.
        s = '0; s.rst = 1;
        applyStimulus(s);
        for (int k = 0; k < 6; k++) begin
            s = '0;
            if (k < 5) begin
                s.id_valid = 1; s.id_rs = 5; s.ex_memRead = 1; s.ex_regWrite = 1; s.ex_dst = 5;
            end
            applyStimulus(s);
            checkOutput($sformatf("perf_sat%0d.stall_cycles", k), stall_cycles_b, sat_seq[k]);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            s = '0;
            s.rst         = ($urandom_range(0, 63) == 0);
            s.id_valid    = ($urandom_range(0, 7) != 0);
            s.id_rs       = pick_reg();
            s.id_rt       = pick_reg();
            s.id_uses_rt  = 1'($urandom_range(0, 1));
            s.cmp_eq      = 1'($urandom_range(0, 1));
            s.ex_regWrite = 1'($urandom_range(0, 1));
            s.ex_memRead  = s.ex_regWrite && ($urandom_range(0, 2) == 0);
            s.ex_dst      = pick_reg();
            s.mem_memRead = ($urandom_range(0, 2) == 0);
            s.mem_dst     = pick_reg();
            cls = $urandom_range(0, 7);
            case (cls)
                0: s.id_is_div     = 1;
                1: s.id_reads_hilo = 1;
                2: s.id_beq        = 1;
                3: s.id_bne        = 1;
                4: s.id_jump       = 1;
                5: s.id_jr         = 1;
                default: ;
            endcase
            applyStimulus(s);
        end
        idleCycles(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and multicycle-sequencing unit for the 5-stage MIPS pipeline, sitting beside the decode-stage control decoder. It detects load-use and branch-operand hazards, tracks a multicycle divider with a configurable latency counter, and produces the PC/IF-ID write enables, ID/EX bubble and IF flush. It also keeps a saturating stall-cycle counter for performance measurement. It replaces the inline `divOP`/`jrOP`/`cmp_eq` handling previously folded into the decoder.

## Interface
- `REG_AW`, 5: register address width.
- `DIV_LATENCY`, 32: divider cycles after issue, legal range 1..255.
- `PERF_W`, 16: stall counter width.
- `clk` in 1: clock; rising-edge.
- `rst` in 1: reset; synchronous and active-high.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in REG_AW: ID source registers.
- `id_uses_rt` in 1: ID reads `id_rt` as a source.
- `id_is_div` in 1: ID instruction is DIV/DIVU.
- `id_reads_hilo` in 1: ID is MFHI/MFLO.
- `id_beq`, `id_bne`, `id_jump`, `id_jr` in 1: ID control-flow class; at most one is set.
- `cmp_eq` in 1: ID comparator result for (rs == rt).
- `ex_regWrite`, `ex_memRead` in 1: EX-stage controls.
- `ex_dst` in REG_AW: EX destination register.
- `mem_memRead` in 1: MEM-stage load flag.
- `mem_dst` in REG_AW: MEM destination register.
- `pc_write` out 1: PC update enable.
- `ifid_write` out 1: IF/ID update enable.
- `idex_bubble` out 1: zero ID/EX control fields.
- `if_flush` out 1: squash the IF/ID instruction.
- `div_start` out 1: divider issue pulse.
- `div_busy` out 1: divider in flight.
- `stall_cycles` out PERF_W: saturating count of stall cycles.

## Operation
- Register 0 never matches; all match terms require a nonzero destination.
- Load-use hazard (`lu`): `ex_memRead` and `ex_dst` equals `id_rs`, or equals `id_rt` when `id_uses_rt`.
- Branch hazard (`br`): applies when `id_beq|id_bne|id_jr`. Triggered by `ex_regWrite` with an `ex_dst` match, or by `mem_memRead` with a `mem_dst` match. For `br`, rt counts as a source for beq/bne only.
- Divider hazard (`dv`): `div_busy` and (`id_is_div|id_reads_hilo`).
- `stall = id_valid & (lu|br|dv)`.
- On stall: `pc_write=0`, `ifid_write=0`, `idex_bubble=1`, `if_flush=0`, `div_start=0`. Otherwise `pc_write=ifid_write=1` and `idex_bubble=0`.
- Taken transfer (not stalled, `id_valid`): `id_jump`, `id_jr`, `id_beq&cmp_eq`, or `id_bne&~cmp_eq` gives `if_flush=1`. A stall always suppresses the flush, because the branch re-resolves when its operands are valid.
- Divider FSM, IDLE/BUSY, uses an 8-bit down-counter `cnt`.
  - In IDLE, `id_valid&id_is_div&~stall` asserts `div_start` and loads `cnt=DIV_LATENCY`, moving to BUSY.
  - In BUSY, `cnt` decrements each cycle and the FSM returns to IDLE when `cnt` reaches 0.
  - `div_busy = (cnt!=0)`.
  - A DIV in ID while BUSY stalls; it is never queued.
- `stall_cycles` increments on every cycle where `stall=1` and holds at all-ones.

## Timing
- All hazard, flush and enable outputs are combinational from the current inputs and `cnt`. `cnt` and `stall_cycles` are registered.
- Reset (when `rst=1` at an edge): `cnt=0`, `stall_cycles=0`, FSM goes to IDLE. While `rst` is high, outputs are forced to `pc_write=1`, `ifid_write=1`, `idex_bubble=1`, `if_flush=1`, `div_start=0`.
- Reset asserted mid-division aborts it. `div_busy=0` the cycle after the reset edge.
- Division issued in cycle T: `div_busy=1` in cycles T+1..T+DIV_LATENCY and 0 in T+DIV_LATENCY+1. In that cycle an MFHI in ID proceeds, and a new DIV may issue.
- Load-use stall lasts 1 cycle: the load moves to MEM and forwarding covers the rest.
- Branch behind an ALU op stalls 1 cycle. Branch behind a load stalls 2 cycles: the EX-match cycle, then the MEM-match cycle.
- `stall_cycles` reflects a stall one cycle after it occurs.

## Test plan
- Reset with `DIV_LATENCY=4`: issue DIV in cycle 0, then assert `rst` in cycle 2. Required: `div_busy=0` in cycle 3, `stall_cycles=0`, and a DIV in cycle 3 gets `div_start=1`.
- Load-use: `ex_memRead=1`, `ex_dst=8`, `id_rs=8`. Required: `pc_write=0`, `idex_bubble=1` for exactly one cycle. Repeat with `ex_dst=0`: required no stall.
- Branch after load: LW r9, then BEQ r9,r10 with `cmp_eq=1`. Required: 2 stall cycles with `if_flush=0`, then `if_flush=1`, and `stall_cycles` +2.
- Divider: `DIV_LATENCY=3`, DIV at T, MFLO in ID from T+1. Required: stall in T+1..T+3, proceeds at T+4; a back-to-back DIV at T+1 gives `div_start` only at T+4.
- BNE with `cmp_eq=0` and no hazard: `if_flush=1`, `pc_write=1`. With `cmp_eq=1`: `if_flush=0`. JR r31 with `ex_regWrite=1`, `ex_dst=31`: stall 1, then flush.
- `PERF_W=2`: hold a stall for 5 cycles. Required: `stall_cycles` sequence 1,2,3,3,3.
